ffss: RTL and testbench

- Modular subtractor over GF(p), p = 2^255 − 19 (Curve25519 field); computes out = (a_i − b_i) mod p.
- Building block of the ECC scalar-multiplication datapath, alongside the other field-arithmetic units.
- Limb-serial, constant-time: every operation takes the same number of cycles regardless of operand values.

---
 rtl/ffss.sv | 151 +++++++++++++++
 tb/tb_ffss.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffss.sv
// ffss: limb-serial modular subtractor over GF(2^255 - 19).
// Computes (a_i - b_i) mod p in a fixed number of cycles. The first pass
// subtracts the operands limb by limb. The second pass always runs, and it
// adds either p or zero depending on the sign of the first result.
module ffss #(
    parameter int           LIMB_W = 64,
    parameter logic [255:0] P      = 256'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] a_i,
    input  logic [254:0] b_i,
    output logic [254:0] out,
    output logic         done
);

    localparam int NLIMB = 256 / LIMB_W;
    localparam int IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CORR = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // d_reg holds the minuend, then the difference, then the corrected result.
    // s_reg holds the subtrahend during SUB and the correction term (P or 0)
    // during CORR. Both registers rotate right by one limb per cycle. The
    // limb being processed is therefore always at the bottom, and after
    // NLIMB cycles each register is back in its natural order.
    logic [255:0]       d_reg;
    logic [255:0]       s_reg;
    logic [IDX_W-1:0]   idx;
    logic               cy;

    logic [LIMB_W-1:0]  d_lo;
    logic [LIMB_W-1:0]  s_lo;
    logic [LIMB_W:0]    sub_r;
    logic [LIMB_W:0]    add_r;
    logic               last;

    // x - y - bin on one limb; the top bit of the result is the borrow out.
    function automatic logic [LIMB_W:0] limb_sub(input logic [LIMB_W-1:0] x,
                                                 input logic [LIMB_W-1:0] y,
                                                 input logic              bin);
        return {1'b0, x} - {1'b0, y} - {{LIMB_W{1'b0}}, bin};
    endfunction

    // x + y + cin on one limb; the top bit of the result is the carry out.
    function automatic logic [LIMB_W:0] limb_add(input logic [LIMB_W-1:0] x,
                                                 input logic [LIMB_W-1:0] y,
                                                 input logic              cin);
        return {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, cin};
    endfunction

    // Insert a new top limb and drop the bottom limb. This also works for
    // NLIMB == 1.
    function automatic logic [255:0] rot_in(input logic [LIMB_W-1:0] top,
                                            input logic [255:0]      r);
        return 256'({top, r} >> LIMB_W);
    endfunction

    assign d_lo  = d_reg[LIMB_W-1:0];
    assign s_lo  = s_reg[LIMB_W-1:0];
    assign sub_r = limb_sub(d_lo, s_lo, cy);
    assign add_r = limb_add(d_lo, s_lo, cy);
    assign last  = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a fixed walk of IDLE -> SUB -> CORR -> FIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SUB;
            SUB:     if (last)  state_nxt = CORR;
            CORR:    if (last)  state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, limb-serial subtract/correct, and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg <= '0;
            s_reg <= '0;
            idx   <= '0;
            cy    <= 1'b0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg <= {1'b0, a_i};
                        s_reg <= {1'b0, b_i};
                        cy    <= 1'b0;
                        idx   <= '0;
                        done  <= 1'b0;
                    end
                end
                SUB: begin
                    d_reg <= rot_in(sub_r[LIMB_W-1:0], d_reg);
                    if (last) begin
                        // The final borrow means a < b. In that case p is
                        // loaded as the correction term; otherwise zero is
                        // loaded, so the CORR pass costs the same either way.
                        s_reg <= sub_r[LIMB_W] ? P : '0;
                        cy    <= 1'b0;
                        idx   <= '0;
                    end else begin
                        s_reg <= rot_in(s_lo, s_reg);
                        cy    <= sub_r[LIMB_W];
                        idx   <= idx + 1'b1;
                    end
                end
                CORR: begin
                    d_reg <= rot_in(add_r[LIMB_W-1:0], d_reg);
                    s_reg <= rot_in(s_lo, s_reg);
                    if (last) begin
                        // Carry out of bit 255 is the 2^256 wrap and is dropped.
                        cy  <= 1'b0;
                        idx <= '0;
                    end else begin
                        cy  <= add_r[LIMB_W];
                        idx <= idx + 1'b1;
                    end
                end
                FIN: begin
                    out  <= d_reg[254:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ffss.sv
// tb_ffss: self-checking bench for the GF(2^255-19) modular subtractor.
// Expected results come from a plain modular-arithmetic reference model and
// from fixed known-answer constants.
module tb_ffss;

    localparam logic [254:0] PMOD = {255{1'b1}} - 255'd18;
    localparam int TIMEOUT = 40;
    localparam int LAT     = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [254:0] a_i;
    logic [254:0] b_i;
    logic [254:0] out;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    ffss dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_i   (a_i),
        .b_i   (b_i),
        .out   (out),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference model: exact integer difference, plus p if it went negative.
    // Operands at or above p are not reduced first.
    function automatic logic [254:0] ref_sub(input logic [254:0] a, input logic [254:0] b);
        logic [256:0] r;
        r = {2'b00, a} - {2'b00, b};
        if (a < b) r = r + {2'b00, PMOD};
        return r[254:0];
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[254:0];
    endfunction

    function automatic logic [254:0] rand_fe();
        logic [254:0] r;
        r = rand255();
        if (r >= PMOD) r[254] = 1'b0;
        return r;
    endfunction

    // Present an operand pair with start for one edge. Afterwards the inputs
    // are scrambled to confirm that the DUT latched them.
    task automatic launch(input logic [254:0] a, input logic [254:0] b);
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_i   = rand255();
        b_i   = rand255();
    endtask

    // Count edges until done is seen high, giving up after TIMEOUT edges.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%h done=%b, want out=0 done=0", out, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known(input string name, input logic [254:0] a, input logic [254:0] b,
                              input logic [254:0] want);
        int lat;
        launch(a, b);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_clear: done=%b after start edge, want 0", name, done);
        end
        wait_done(lat);
        n_checks++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: %0d edges, want %0d", name, lat, LAT);
        end
        n_checks++;
        if (out !== want) begin
            n_fail++;
            $display("FAIL %s_value: out=%h want=%h", name, out, want);
        end
        n_checks++;
        if (ref_sub(a, b) !== want) begin
            n_fail++;
            $display("FAIL %s_model: model=%h want=%h", name, ref_sub(a, b), want);
        end
    endtask

    task automatic test_hold();
        logic [254:0] held;
        held = out;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || out !== held) begin
            n_fail++;
            $display("FAIL hold: done=%b out=%h, want done=1 out=%h", done, out, held);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [254:0] a;
        logic [254:0] b;
        int lat;
        launch(255'd7, 255'd3);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out=%h done=%b, want out=0 done=0", out, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: done=%b after aborted op, want 0", done);
        end
        a = rand_fe();
        b = rand_fe();
        launch(a, b);
        wait_done(lat);
        n_checks++;
        if (done !== 1'b1 || out !== ref_sub(a, b)) begin
            n_fail++;
            $display("FAIL reset_recover: done=%b out=%h want=%h", done, out, ref_sub(a, b));
        end
    endtask

    task automatic test_random(input int n, input bit oor);
        logic [254:0] a;
        logic [254:0] b;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = oor ? (PMOD + 255'($urandom_range(0, 18))) : rand_fe();
            b = (oor && i[0]) ? (PMOD + 255'($urandom_range(0, 18))) : rand_fe();
            launch(a, b);
            wait_done(lat);
            n_checks++;
            if (lat != LAT || out !== ref_sub(a, b)) begin
                n_fail++;
                $display("FAIL random%0d: lat=%0d out=%h, want lat=%0d out=%h (a=%h b=%h)",
                         i, lat, out, LAT, ref_sub(a, b), a, b);
            end
        end
    endtask

    task automatic test_busy_ignored();
        logic [254:0] a;
        logic [254:0] b;
        int lat;
        a = rand_fe();
        b = rand_fe();
        launch(a, b);
        repeat (4) begin
            @(negedge clk);
            start = 1'b1;
            a_i   = rand255();
            b_i   = rand255();
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(lat);
        n_checks++;
        if (done !== 1'b1 || out !== ref_sub(a, b)) begin
            n_fail++;
            $display("FAIL busy_ignored: done=%b out=%h want=%h", done, out, ref_sub(a, b));
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_no_restart: done=%b, want 1", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [254:0] a;
        logic [254:0] b;
        int lat;
        int low_bad;
        a = rand_fe();
        b = rand_fe();
        launch(rand_fe(), rand_fe());
        wait_done(lat);
        // Assert start in the same cycle that done is first seen high.
        start = 1'b1;
        a_i   = a;
        b_i   = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a_i     = rand255();
        b_i     = rand255();
        low_bad = (done !== 1'b0) ? 1 : 0;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) low_bad++;
        end
        n_checks++;
        if (low_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_done_low: done high in %0d of %0d cycles, want 0", low_bad, LAT);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || out !== ref_sub(a, b)) begin
            n_fail++;
            $display("FAIL b2b_result: done=%b out=%h want=%h", done, out, ref_sub(a, b));
        end
    endtask

    initial begin
        test_reset();
        test_known("kat1",
            255'd44927731495623270119727621215091840270797887326986279676957494683529379806913,
            255'd45965849458578823337785628114947185621072782472466027602082789798859530730301,
            255'd56857926655702544493727485604488608576360097187340534094603496888626413896561);
        test_hold();
        test_known("kat1_swap",
            255'd45965849458578823337785628114947185621072782472466027602082789798859530730301,
            255'd44927731495623270119727621215091840270797887326986279676957494683529379806913,
            255'd1038117962955553218058006899855345350274895145479747925125295115330150923388);
        test_known("equal", 255'd12345, 255'd12345, 255'd0);
        test_known("zero_minus_one", 255'd0, 255'd1,
            255'd57896044618658097711785492504343953926634992332820282019728792003956564819948);
        test_known("pm1_minus_zero", PMOD - 255'd1, 255'd0, PMOD - 255'd1);
        test_known("limb_borrow", 255'd1 << 64, 255'd1, (255'd1 << 64) - 255'd1);
        test_known("oor_max", {255{1'b1}}, 255'd0, {255{1'b1}});
        test_reset_mid_op();
        test_random(16, 1'b0);
        test_random(4, 1'b1);
        test_busy_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
